apb3_bridge_ctrl: RTL and testbench

//  Parametrised AHB-to-APB3 bridge controller. Accepts qualified AHB transfers (valid) and decodes
//  a one-hot PSEL over NUM_SLAVES. Runs APB3 SETUP/ACCESS with PREADY wait states, PSLVERR and a

---
 rtl/apb3_bridge_ctrl_if.sv | 47 ++++
 rtl/apb3_bridge_ctrl.sv | 167 ++++++++++++++++
 tb/tb_apb3_bridge_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/apb3_bridge_ctrl_if.sv
// rtl/apb3_bridge_ctrl_if.sv - AHB-side and APB-side signal bundle for the bridge controller
//
// Purpose: groups the qualified AHB transfer inputs, the AHB response outputs and the
//          APB3 master signals of apb3_bridge_ctrl into one bundle.
// Modports:
//   master : bridge view (drives AHB response and APB request, reads AHB request / APB response)
//   slave  : environment view (AHB slave interface regs plus APB slave mux)
// Signals:
//   valid, haddr, hwrite, hwdata        AHB qualified transfer in
//   hreadyout, hresp, hrdata            AHB response out
//   psel, penable, pwrite, paddr, pwdata APB request out
//   prdata, pready, pslverr             APB response in
//   timeout_o                           1-cycle pulse on wait-state timeout abort

interface apb3_bridge_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic                  valid;
    logic [ADDR_W-1:0]     haddr;
    logic                  hwrite;
    logic [DATA_W-1:0]     hwdata;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_W-1:0]     hrdata;
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;
    logic                  timeout_o;

    // The bridge is the APB master, hence "master" is the bridge-side view.
    modport master (
        input  valid, haddr, hwrite, hwdata, prdata, pready, pslverr,
        output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata, timeout_o
    );

    modport slave (
        output valid, haddr, hwrite, hwdata, prdata, pready, pslverr,
        input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata, timeout_o
    );
endinterface

// File: rtl/apb3_bridge_ctrl.sv
// rtl/apb3_bridge_ctrl.sv - AHB-to-APB3 bridge controller with decode, wait states and timeout
//
// Purpose: accepts qualified AHB transfers, decodes a one-hot PSEL, runs APB3 SETUP/ACCESS
//          with PREADY wait states, PSLVERR mapping and a wait-state timeout, and returns the
//          two-cycle AHB ERROR response on decode error, slave error or timeout.
// Ports:
//   hclk     in  clock, single domain
//   hresetn  in  synchronous reset, active-high (name kept from the AHB side)
//   bus      apb3_bridge_ctrl_if.master, all bus signals; every output is registered

module apb3_bridge_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_LSB    = 12,
    parameter int TIMEOUT    = 16,
    parameter int PSLVERR_EN = 1
) (
    input  logic                hclk,
    input  logic                hresetn,
    apb3_bridge_ctrl_if.master  bus
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                r_state;
    logic [SEL_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_hreadyout;
    logic                  r_hresp;
    logic [DATA_W-1:0]     r_hrdata;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;
    logic                  r_timeout;

    logic [SEL_W-1:0]      w_hidx;
    logic                  w_dec_err;
    logic [NUM_SLAVES-1:0] w_hsel;
    logic [NUM_SLAVES-1:0] w_rsel;
    logic                  w_tmo_hit;
    logic                  w_slv_err;

    always_comb begin
        w_hidx    = bus.haddr[SLV_LSB +: SEL_W];
        // Extra MSB so NUM_SLAVES == 2**SEL_W is representable in the compare.
        w_dec_err = ({1'b0, w_hidx} >= (SEL_W + 1)'(NUM_SLAVES));
        w_hsel    = '0;
        w_rsel    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_hsel[i] = (w_hidx == SEL_W'(i));
            w_rsel[i] = (r_idx == SEL_W'(i));
        end
        // r_wait_cnt holds the number of earlier non-ready ACCESS cycles, so the
        // TIMEOUT-th ACCESS cycle is the one where it equals TIMEOUT-1.
        w_tmo_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));
        w_slv_err = bus.pslverr && (PSLVERR_EN != 0);
    end

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.valid) begin
                        r_paddr     <= bus.haddr;
                        r_pwrite    <= bus.hwrite;
                        r_idx       <= w_hidx;
                        r_hreadyout <= 1'b0;
                        if (w_dec_err) begin
                            r_hresp <= 1'b1;
                            r_state <= S_ERR1;
                        end else if (bus.hwrite) begin
                            r_state <= S_WWAIT;
                        end else begin
                            // Read skips WWAIT, so select from the live address.
                            r_psel  <= w_hsel;
                            r_state <= S_SETUP;
                        end
                    end
                end
                S_WWAIT: begin
                    r_pwdata <= bus.hwdata;
                    r_psel   <= w_rsel;
                    r_state  <= S_SETUP;
                end
                S_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus.pready) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        if (w_slv_err) begin
                            r_hresp <= 1'b1;
                            r_state <= S_ERR1;
                        end else begin
                            r_hreadyout <= 1'b1;
                            if (!r_pwrite) begin
                                r_hrdata <= bus.prdata;
                            end
                            r_state <= S_IDLE;
                        end
                    end else if (w_tmo_hit) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_hresp   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_ERR1;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_ERR1: begin
                    r_hreadyout <= 1'b1;
                    r_state     <= S_ERR2;
                end
                S_ERR2: begin
                    // valid here belongs to a transfer the master must cancel.
                    r_hresp <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hreadyout = r_hreadyout;
    assign bus.hresp     = r_hresp;
    assign bus.hrdata    = r_hrdata;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.timeout_o = r_timeout;

endmodule

// File: tb/tb_apb3_bridge_ctrl.sv
// tb/tb_apb3_bridge_ctrl.sv - directed self-checking bench for apb3_bridge_ctrl

module tb_apb3_bridge_ctrl;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        valid0, valid1, valid2;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 hclk = ~hclk;

    apb3_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) if0 ();
    apb3_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) if1 ();
    apb3_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) if2 ();

    assign if0.valid = valid0;  assign if1.valid = valid1;  assign if2.valid = valid2;
    assign if0.haddr = haddr;   assign if1.haddr = haddr;   assign if2.haddr = haddr;
    assign if0.hwrite = hwrite; assign if1.hwrite = hwrite; assign if2.hwrite = hwrite;
    assign if0.hwdata = hwdata; assign if1.hwdata = hwdata; assign if2.hwdata = hwdata;
    assign if0.prdata = prdata; assign if1.prdata = prdata; assign if2.prdata = prdata;
    assign if0.pready = pready; assign if1.pready = pready; assign if2.pready = pready;
    assign if0.pslverr = pslverr; assign if1.pslverr = pslverr; assign if2.pslverr = pslverr;

    apb3_bridge_ctrl dut0 (.hclk(hclk), .hresetn(hresetn), .bus(if0));
    apb3_bridge_ctrl #(.PSLVERR_EN(0)) dut1 (.hclk(hclk), .hresetn(hresetn), .bus(if1));
    apb3_bridge_ctrl #(.NUM_SLAVES(3)) dut2 (.hclk(hclk), .hresetn(hresetn), .bus(if2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge hclk);
    endtask

    initial begin
        hresetn = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        haddr = '0; hwrite = 1'b0; hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        step(); step();

        chk("rst_hreadyout", 64'(if0.hreadyout), 64'h1);
        chk("rst_hresp",     64'(if0.hresp),     64'h0);
        chk("rst_hrdata",    64'(if0.hrdata),    64'h0);
        chk("rst_psel",      64'(if0.psel),      64'h0);
        chk("rst_penable",   64'(if0.penable),   64'h0);
        chk("rst_paddr",     64'(if0.paddr),     64'h0);
        chk("rst_pwdata",    64'(if0.pwdata),    64'h0);
        chk("rst_timeout",   64'(if0.timeout_o), 64'h0);
        hresetn = 1'b0;
        step();

        // Read, zero wait states
        valid0 = 1'b1; haddr = 32'h0000_2010; hwrite = 1'b0; pready = 1'b1; prdata = 32'hDEAD_BEEF;
        step(); valid0 = 1'b0;
        chk("rd_setup_psel",    64'(if0.psel),      64'h4);
        chk("rd_setup_penable", 64'(if0.penable),   64'h0);
        chk("rd_setup_hready",  64'(if0.hreadyout), 64'h0);
        chk("rd_setup_paddr",   64'(if0.paddr),     64'h2010);
        step();
        chk("rd_acc_penable",   64'(if0.penable),   64'h1);
        chk("rd_acc_psel",      64'(if0.psel),      64'h4);
        step();
        chk("rd_done_hready",   64'(if0.hreadyout), 64'h1);
        chk("rd_done_hresp",    64'(if0.hresp),     64'h0);
        chk("rd_done_hrdata",   64'(if0.hrdata),    64'hDEAD_BEEF);
        chk("rd_done_psel",     64'(if0.psel),      64'h0);

        // Write with two wait states
        valid0 = 1'b1; haddr = 32'h0000_1004; hwrite = 1'b1; pready = 1'b0;
        step(); valid0 = 1'b0; hwdata = 32'hA5A5_0001;
        chk("wr_wwait_hready",  64'(if0.hreadyout), 64'h0);
        chk("wr_wwait_psel",    64'(if0.psel),      64'h0);
        step(); hwdata = 32'h0;
        chk("wr_setup_psel",    64'(if0.psel),      64'h2);
        chk("wr_setup_pwrite",  64'(if0.pwrite),    64'h1);
        chk("wr_setup_pwdata",  64'(if0.pwdata),    64'hA5A5_0001);
        chk("wr_setup_penable", 64'(if0.penable),   64'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i == 3) pready = 1'b1;
            chk("wr_acc_penable", 64'(if0.penable),   64'h1);
            chk("wr_acc_psel",    64'(if0.psel),      64'h2);
            chk("wr_acc_paddr",   64'(if0.paddr),     64'h1004);
            chk("wr_acc_pwdata",  64'(if0.pwdata),    64'hA5A5_0001);
            chk("wr_acc_hready",  64'(if0.hreadyout), 64'h0);
        end
        step(); pready = 1'b0;
        chk("wr_done_hready",   64'(if0.hreadyout), 64'h1);
        chk("wr_done_hrdata",   64'(if0.hrdata),    64'hDEAD_BEEF);

        // PSLVERR mapped to ERROR
        valid0 = 1'b1; haddr = 32'h0; hwrite = 1'b0; pready = 1'b1; pslverr = 1'b1;
        prdata = 32'h1234_5678;
        step(); valid0 = 1'b0;
        step();
        step();
        chk("se_err1_psel",     64'(if0.psel),      64'h0);
        chk("se_err1_hresp",    64'(if0.hresp),     64'h1);
        chk("se_err1_hready",   64'(if0.hreadyout), 64'h0);
        step();
        chk("se_err2_hresp",    64'(if0.hresp),     64'h1);
        chk("se_err2_hready",   64'(if0.hreadyout), 64'h1);
        chk("se_err2_hrdata",   64'(if0.hrdata),    64'hDEAD_BEEF);
        step();
        chk("se_idle_hresp",    64'(if0.hresp),     64'h0);

        // PSLVERR ignored when PSLVERR_EN=0
        valid1 = 1'b1;
        step(); valid1 = 1'b0;
        step();
        step();
        chk("se0_hresp",        64'(if1.hresp),     64'h0);
        chk("se0_hready",       64'(if1.hreadyout), 64'h1);
        chk("se0_hrdata",       64'(if1.hrdata),    64'h1234_5678);
        pslverr = 1'b0;

        // Timeout: pready held low
        valid0 = 1'b1; haddr = 32'h0000_3000; hwrite = 1'b0; pready = 1'b0;
        step(); valid0 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("to_acc_penable", 64'(if0.penable),   64'h1);
            chk("to_acc_pulse",   64'(if0.timeout_o), 64'h0);
        end
        step();
        chk("to_err1_pulse",    64'(if0.timeout_o), 64'h1);
        chk("to_err1_penable",  64'(if0.penable),   64'h0);
        chk("to_err1_hresp",    64'(if0.hresp),     64'h1);
        chk("to_err1_hready",   64'(if0.hreadyout), 64'h0);
        step();
        chk("to_err2_pulse",    64'(if0.timeout_o), 64'h0);
        chk("to_err2_hready",   64'(if0.hreadyout), 64'h1);
        step();

        // pready on the 16th ACCESS cycle wins over the timeout
        valid0 = 1'b1; prdata = 32'hCAFE_F00D;
        step(); valid0 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 16) pready = 1'b1;
            chk("tw_acc_penable", 64'(if0.penable), 64'h1);
        end
        step(); pready = 1'b0;
        chk("tw_pulse",         64'(if0.timeout_o), 64'h0);
        chk("tw_hresp",         64'(if0.hresp),     64'h0);
        chk("tw_hready",        64'(if0.hreadyout), 64'h1);
        chk("tw_hrdata",        64'(if0.hrdata),    64'hCAFE_F00D);

        // Decode error with NUM_SLAVES=3
        valid2 = 1'b1; haddr = 32'h0000_3000; hwrite = 1'b0; pready = 1'b1;
        step(); valid2 = 1'b0;
        chk("de_err1_psel",     64'(if2.psel),      64'h0);
        chk("de_err1_hresp",    64'(if2.hresp),     64'h1);
        chk("de_err1_hready",   64'(if2.hreadyout), 64'h0);
        step();
        valid2 = 1'b1; haddr = 32'h0000_1000;
        chk("de_err2_psel",     64'(if2.psel),      64'h0);
        chk("de_err2_hresp",    64'(if2.hresp),     64'h1);
        chk("de_err2_hready",   64'(if2.hreadyout), 64'h1);
        step(); valid2 = 1'b0;
        chk("de_idle_hresp",    64'(if2.hresp),     64'h0);
        step();
        chk("de_ign_hready",    64'(if2.hreadyout), 64'h1);
        chk("de_ign_psel",      64'(if2.psel),      64'h0);

        // Back-to-back read then write, then reset during ACCESS
        valid0 = 1'b1; haddr = 32'h0000_2010; hwrite = 1'b0; pready = 1'b1; prdata = 32'h0BAD_CAFE;
        step(); valid0 = 1'b0;
        step();
        step();
        chk("bb_rd_hready",     64'(if0.hreadyout), 64'h1);
        chk("bb_rd_hrdata",     64'(if0.hrdata),    64'h0BAD_CAFE);
        valid0 = 1'b1; haddr = 32'h0000_1004; hwrite = 1'b1;
        step(); valid0 = 1'b0; hwdata = 32'h5A5A_5A5A;
        chk("bb_wr_accepted",   64'(if0.hreadyout), 64'h0);
        step(); pready = 1'b0;
        chk("bb_wr_psel",       64'(if0.psel),      64'h2);
        chk("bb_wr_pwdata",     64'(if0.pwdata),    64'h5A5A_5A5A);
        step();
        chk("bb_acc_penable",   64'(if0.penable),   64'h1);
        hresetn = 1'b1;
        step();
        chk("mr_hready",        64'(if0.hreadyout), 64'h1);
        chk("mr_hresp",         64'(if0.hresp),     64'h0);
        chk("mr_psel",          64'(if0.psel),      64'h0);
        chk("mr_penable",       64'(if0.penable),   64'h0);
        chk("mr_pwrite",        64'(if0.pwrite),    64'h0);
        chk("mr_hrdata",        64'(if0.hrdata),    64'h0);
        chk("mr_paddr",         64'(if0.paddr),     64'h0);
        chk("mr_pwdata",        64'(if0.pwdata),    64'h0);
        hresetn = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
